// File: rtl/branch_stack_pkg.sv
// Shared sizes and types for the branch checkpoint stack.
package branch_stack_pkg;

    localparam int unsigned ARCH_REG_SZ_R10K           = 32;
    localparam int unsigned PHYS_REG_SZ_R10K           = 64;
    localparam int unsigned PHYS_REG_IDX               = $clog2(PHYS_REG_SZ_R10K);
    localparam int unsigned BRANCH_STACK_DEPTH_DEFAULT = 4;

    typedef logic [BRANCH_STACK_DEPTH_DEFAULT-1:0]           BRANCH_MASK;
    typedef logic [PHYS_REG_SZ_R10K-1:0]                     FREE_LIST_T;
    typedef logic [ARCH_REG_SZ_R10K-1:0][PHYS_REG_IDX-1:0]   MAP_TABLE_T;

endpackage

// File: rtl/branch_stack_psel_gen.sv
// Single-grant priority selector: grants the lowest-index asserted request.
module branch_stack_psel_gen #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt
);

    logic found;

    // Walk from index 0 upward and stop at the first request.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_stack.sv
// Checkpoint store for speculative branches: snapshots free list and map
// table at branch dispatch, restores and squashes on mispredict.
module branch_stack
    import branch_stack_pkg::*;
#(
    parameter int unsigned BRANCH_STACK_DEPTH = BRANCH_STACK_DEPTH_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          dispatch_branch_valid,
    input  logic [PHYS_REG_SZ_R10K-1:0]   dispatch_free_list,
    input  MAP_TABLE_T                    dispatch_map_table,
    output logic [BRANCH_STACK_DEPTH-1:0] branch_tag,
    output logic                          stack_full,
    input  logic                          resolve_valid,
    input  logic [BRANCH_STACK_DEPTH-1:0] resolve_tag,
    input  logic                          resolve_mispredict,
    output logic                          restore_flag,
    output logic [PHYS_REG_SZ_R10K-1:0]   free_list_restore,
    output MAP_TABLE_T                    map_table_restore,
    output logic [BRANCH_STACK_DEPTH-1:0] squash_mask,
    output logic [BRANCH_STACK_DEPTH-1:0] resolved_mask,
    output logic [BRANCH_STACK_DEPTH-1:0] live_mask
);

    localparam int unsigned D = BRANCH_STACK_DEPTH;

    logic [D-1:0]                valid_q;
    logic [D-1:0]                valid_d;
    logic [PHYS_REG_SZ_R10K-1:0] free_list_q [D];
    MAP_TABLE_T                  map_table_q [D];
    logic [D-1:0]                older_mask_q [D];
    logic [D-1:0]                older_mask_d [D];

    logic [D-1:0] alloc_gnt;
    logic [D-1:0] hit_mask;
    logic         mispredict;
    logic         correct;
    logic         alloc;

    branch_stack_psel_gen #(
        .WIDTH(D)
    ) u_alloc_sel (
        .req(~valid_q),
        .gnt(alloc_gnt)
    );

    // Allocation and resolve decode, all from registered state.
    always_comb begin
        branch_tag    = alloc_gnt;
        stack_full    = &valid_q;
        live_mask     = valid_q;
        hit_mask      = resolve_valid ? (resolve_tag & valid_q) : '0;
        mispredict    = (|hit_mask) && resolve_mispredict;
        correct       = (|hit_mask) && !resolve_mispredict;
        resolved_mask = correct ? hit_mask : '0;
        restore_flag  = mispredict;
        // An incoming branch is younger than a mispredicted one, so it is dropped.
        alloc         = dispatch_branch_valid && !stack_full && !mispredict;
    end

    // Restore vectors and squash set for a mispredicted checkpoint.
    always_comb begin
        free_list_restore = '0;
        map_table_restore = '0;
        squash_mask       = '0;
        if (mispredict) begin
            squash_mask = hit_mask;
            for (int i = 0; i < D; i++) begin
                if (hit_mask[i]) begin
                    free_list_restore = free_list_restore | free_list_q[i];
                    map_table_restore = map_table_restore | map_table_q[i];
                end
                // Any live entry that recorded the mispredicted tag as older is younger.
                if (valid_q[i] && (|(older_mask_q[i] & hit_mask))) begin
                    squash_mask[i] = 1'b1;
                end
            end
        end
    end

    // Next-state valid bits and age masks.
    always_comb begin
        valid_d = (valid_q & ~squash_mask & ~resolved_mask) | (alloc ? alloc_gnt : '0);
        for (int i = 0; i < D; i++) begin
            older_mask_d[i] = older_mask_q[i] & ~resolved_mask & ~squash_mask;
            // Tag released this cycle is already gone, so it must not be recorded as older.
            if (alloc && alloc_gnt[i]) begin
                older_mask_d[i] = valid_q & ~resolved_mask;
            end
        end
    end

    // Checkpoint state registers; reset wins over resolve and allocation.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < D; i++) begin
                free_list_q[i]  <= '0;
                map_table_q[i]  <= '0;
                older_mask_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < D; i++) begin
                older_mask_q[i] <= older_mask_d[i];
                if (alloc && alloc_gnt[i]) begin
                    free_list_q[i] <= dispatch_free_list;
                    map_table_q[i] <= dispatch_map_table;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_stack.sv
// Self-checking bench for branch_stack: scenario tasks with a queue of
// expected values pushed at stimulus time and popped at sampling time.
module tb_branch_stack;
    import branch_stack_pkg::*;

    localparam int unsigned D = 4;

    logic                        clock;
    logic                        reset;
    logic                        dispatch_branch_valid;
    logic [PHYS_REG_SZ_R10K-1:0] dispatch_free_list;
    MAP_TABLE_T                  dispatch_map_table;
    logic [D-1:0]                branch_tag;
    logic                        stack_full;
    logic                        resolve_valid;
    logic [D-1:0]                resolve_tag;
    logic                        resolve_mispredict;
    logic                        restore_flag;
    logic [PHYS_REG_SZ_R10K-1:0] free_list_restore;
    MAP_TABLE_T                  map_table_restore;
    logic [D-1:0]                squash_mask;
    logic [D-1:0]                resolved_mask;
    logic [D-1:0]                live_mask;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q [$];
    logic [63:0] exp_v;
    MAP_TABLE_T  mt_a;

    branch_stack #(
        .BRANCH_STACK_DEPTH(D)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .dispatch_branch_valid(dispatch_branch_valid),
        .dispatch_free_list   (dispatch_free_list),
        .dispatch_map_table   (dispatch_map_table),
        .branch_tag           (branch_tag),
        .stack_full           (stack_full),
        .resolve_valid        (resolve_valid),
        .resolve_tag          (resolve_tag),
        .resolve_mispredict   (resolve_mispredict),
        .restore_flag         (restore_flag),
        .free_list_restore    (free_list_restore),
        .map_table_restore    (map_table_restore),
        .squash_mask          (squash_mask),
        .resolved_mask        (resolved_mask),
        .live_mask            (live_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dispatch_branch_valid = 1'b0;
        dispatch_free_list    = '0;
        dispatch_map_table    = '0;
        resolve_valid         = 1'b0;
        resolve_tag           = '0;
        resolve_mispredict    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Allocate one branch with the given free list (map table randomised).
    task automatic alloc_one(input logic [63:0] fl);
        idle();
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = fl;
        for (int i = 0; i < ARCH_REG_SZ_R10K; i++) begin
            dispatch_map_table[i] = PHYS_REG_IDX'($urandom);
        end
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(64'h0); // live
        exp_q.push_back(64'h1); // tag
        exp_q.push_back(64'h0); // full, restore_flag, squash, resolved, free_list
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL reset_live: got %0h want %0h", live_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(branch_tag) !== exp_v) begin
            n_err++; $display("FAIL reset_tag: got %0h want %0h", branch_tag, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({stack_full, restore_flag, squash_mask, resolved_mask, free_list_restore} !== 75'(exp_v))
        begin
            n_err++;
            $display("FAIL reset_outputs: full=%b rf=%b sq=%b rs=%b fl=%0h want all 0",
                     stack_full, restore_flag, squash_mask, resolved_mask, free_list_restore);
        end
    endtask

    task automatic test_fill();
        logic [D-1:0] live_before;
        do_reset();
        for (int i = 0; i < D; i++) begin
            exp_q.push_back(64'(1) << i);
            dispatch_branch_valid = 1'b1;
            dispatch_free_list    = 64'(i + 1);
            #2;
            exp_v = exp_q.pop_front(); n_cmp++;
            if (64'(branch_tag) !== exp_v) begin
                n_err++; $display("FAIL fill_tag%0d: got %b want %0h", i, branch_tag, exp_v);
            end
            tick();
        end
        idle();
        exp_q.push_back(64'h1);
        exp_q.push_back(64'hF);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(stack_full) !== exp_v) begin
            n_err++; $display("FAIL fill_full: got %b want %0h", stack_full, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL fill_live: got %b want %0h", live_mask, exp_v);
        end
        // Fifth dispatch while full must be ignored.
        live_before = 4'b1111;
        exp_q.push_back(64'(live_before));
        alloc_one(64'hDEAD);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL fill_fifth_ignored: got %b want %0h", live_mask, exp_v);
        end
    endtask

    task automatic test_mispredict_all();
        do_reset();
        idle();
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = 64'hF0;
        for (int i = 0; i < ARCH_REG_SZ_R10K; i++) mt_a[i] = PHYS_REG_IDX'($urandom);
        dispatch_map_table = mt_a;
        tick();
        alloc_one(64'h0F00);
        alloc_one(64'h3000);
        alloc_one(64'h4000);
        resolve_valid      = 1'b1;
        resolve_tag        = 4'b0001;
        resolve_mispredict = 1'b1;
        exp_q.push_back(64'h1);
        exp_q.push_back(64'hF0);
        exp_q.push_back(64'hF);
        exp_q.push_back(64'h0);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(restore_flag) !== exp_v) begin
            n_err++; $display("FAIL mp_restore_flag: got %b want %0h", restore_flag, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (free_list_restore !== exp_v) begin
            n_err++; $display("FAIL mp_free_list: got %0h want %0h", free_list_restore, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(squash_mask) !== exp_v) begin
            n_err++; $display("FAIL mp_squash_all: got %b want %0h", squash_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(resolved_mask) !== exp_v) begin
            n_err++; $display("FAIL mp_resolved_zero: got %b want %0h", resolved_mask, exp_v);
        end
        n_cmp++;
        if (map_table_restore !== mt_a) begin
            n_err++; $display("FAIL mp_map_table: got %0h want %0h", map_table_restore, mt_a);
        end
        tick();
        idle();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL mp_live_after: got %b want %0h", live_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({restore_flag, free_list_restore} !== 65'(exp_v)) begin
            n_err++; $display("FAIL mp_idle_restore: rf=%b fl=%0h want 0", restore_flag,
                              free_list_restore);
        end
    endtask

    task automatic test_resolve_then_mispredict();
        do_reset();
        alloc_one(64'hA);
        alloc_one(64'hB);
        alloc_one(64'hC);
        resolve_valid = 1'b1;
        resolve_tag   = 4'b0010;
        exp_q.push_back(64'h2);
        exp_q.push_back(64'h0);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(resolved_mask) !== exp_v) begin
            n_err++; $display("FAIL rs_resolved: got %b want %0h", resolved_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'({restore_flag, squash_mask}) !== exp_v) begin
            n_err++; $display("FAIL rs_no_squash: rf=%b sq=%b want 0", restore_flag, squash_mask);
        end
        tick();
        idle();
        exp_q.push_back(64'h5);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL rs_live: got %b want %0h", live_mask, exp_v);
        end
        resolve_valid      = 1'b1;
        resolve_tag        = 4'b0001;
        resolve_mispredict = 1'b1;
        exp_q.push_back(64'h5);
        exp_q.push_back(64'hA);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(squash_mask) !== exp_v) begin
            n_err++; $display("FAIL rs_squash: got %b want %0h", squash_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (free_list_restore !== exp_v) begin
            n_err++; $display("FAIL rs_free_list: got %0h want %0h", free_list_restore, exp_v);
        end
        tick();
        idle();
    endtask

    task automatic test_full_resolve_dispatch();
        do_reset();
        for (int i = 0; i < D; i++) alloc_one(64'(i));
        resolve_valid         = 1'b1;
        resolve_tag           = 4'b0100;
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = 64'h77;
        exp_q.push_back(64'h4);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(resolved_mask) !== exp_v) begin
            n_err++; $display("FAIL fr_resolved: got %b want %0h", resolved_mask, exp_v);
        end
        tick();
        idle();
        exp_q.push_back(64'hB);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h0);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL fr_live: got %b want %0h", live_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(branch_tag) !== exp_v) begin
            n_err++; $display("FAIL fr_tag: got %b want %0h", branch_tag, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(stack_full) !== exp_v) begin
            n_err++; $display("FAIL fr_full: got %b want %0h", stack_full, exp_v);
        end
    endtask

    task automatic test_mispredict_vs_dispatch();
        do_reset();
        alloc_one(64'h1);
        alloc_one(64'h2);
        resolve_valid         = 1'b1;
        resolve_tag           = 4'b0010;
        resolve_mispredict    = 1'b1;
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = 64'h99;
        exp_q.push_back(64'h2);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(squash_mask) !== exp_v) begin
            n_err++; $display("FAIL md_squash: got %b want %0h", squash_mask, exp_v);
        end
        tick();
        idle();
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h2);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL md_live: got %b want %0h", live_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(branch_tag) !== exp_v) begin
            n_err++; $display("FAIL md_tag: got %b want %0h", branch_tag, exp_v);
        end
    endtask

    // Correct resolve and allocation in the same cycle; freed slot not reused.
    task automatic test_back_to_back();
        do_reset();
        alloc_one(64'h10);
        alloc_one(64'h20);
        resolve_valid         = 1'b1;
        resolve_tag           = 4'b0001;
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = 64'h40;
        exp_q.push_back(64'h4);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(branch_tag) !== exp_v) begin
            n_err++; $display("FAIL bb_tag: got %b want %0h", branch_tag, exp_v);
        end
        tick();
        idle();
        exp_q.push_back(64'h6);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL bb_live: got %b want %0h", live_mask, exp_v);
        end
        // Reallocated entry 0 is youngest; mispredicting it squashes only itself.
        alloc_one(64'h80);
        resolve_valid      = 1'b1;
        resolve_tag        = 4'b0001;
        resolve_mispredict = 1'b1;
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h80);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(squash_mask) !== exp_v) begin
            n_err++; $display("FAIL bb_squash_young: got %b want %0h", squash_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (free_list_restore !== exp_v) begin
            n_err++; $display("FAIL bb_free_list: got %0h want %0h", free_list_restore, exp_v);
        end
        tick();
        idle();
        // Mispredict entry 1: entry 2 is younger and must go too.
        resolve_valid      = 1'b1;
        resolve_tag        = 4'b0010;
        resolve_mispredict = 1'b1;
        exp_q.push_back(64'h6);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(squash_mask) !== exp_v) begin
            n_err++; $display("FAIL bb_squash_chain: got %b want %0h", squash_mask, exp_v);
        end
        tick();
        idle();
    endtask

    task automatic test_invalid_resolve();
        do_reset();
        alloc_one(64'h5);
        resolve_valid      = 1'b1;
        resolve_tag        = 4'b1000;
        resolve_mispredict = 1'b1;
        exp_q.push_back(64'h0);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({restore_flag, squash_mask, resolved_mask, free_list_restore} !== 73'(exp_v)) begin
            n_err++; $display("FAIL inv_tag_outputs: rf=%b sq=%b rs=%b fl=%0h want 0",
                              restore_flag, squash_mask, resolved_mask, free_list_restore);
        end
        resolve_tag = 4'b0000;
        exp_q.push_back(64'h0);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'({restore_flag, squash_mask, resolved_mask}) !== exp_v) begin
            n_err++; $display("FAIL zero_tag_outputs: rf=%b sq=%b rs=%b want 0",
                              restore_flag, squash_mask, resolved_mask);
        end
        tick();
        idle();
        exp_q.push_back(64'h1);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL inv_live: got %b want %0h", live_mask, exp_v);
        end
    endtask

    task automatic test_reset_during_mispredict();
        do_reset();
        alloc_one(64'h1);
        alloc_one(64'h2);
        resolve_valid      = 1'b1;
        resolve_tag        = 4'b0010;
        resolve_mispredict = 1'b1;
        reset              = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h0);
        #2;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(live_mask) !== exp_v) begin
            n_err++; $display("FAIL rst_mp_live: got %b want %0h", live_mask, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'(branch_tag) !== exp_v) begin
            n_err++; $display("FAIL rst_mp_tag: got %b want %0h", branch_tag, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (64'({stack_full, restore_flag, squash_mask, resolved_mask}) !== exp_v) begin
            n_err++; $display("FAIL rst_mp_outputs: full=%b rf=%b sq=%b rs=%b want 0",
                              stack_full, restore_flag, squash_mask, resolved_mask);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_mispredict_all();
        test_resolve_then_mispredict();
        test_full_resolve_dispatch();
        test_mispredict_vs_dispatch();
        test_back_to_back();
        test_invalid_resolve();
        test_reset_during_mispredict();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
